// File: rtl/prng_lcg_multi.sv
// Linear-congruential PRNG with command handshake, burst generation, output back-pressure,
// abort and a pipelined multiplier. Optional high-bit fold whitening: PRNG_LCG_WHITEN_EN.
module prng_lcg_multi #(
  parameter int                SEED_W   = 32,
  parameter int                OUT_W    = 15,
  parameter int                OUT_LSB  = 16,
  parameter logic [SEED_W-1:0] LCG_MULT = SEED_W'(1103515245),
  parameter logic [SEED_W-1:0] LCG_INCR = SEED_W'(12345),
  parameter int                MUL_LAT  = 1,
  parameter int                BURST_W  = 8
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               cmd_vld,
  output logic               cmd_rdy,
  input  logic               cmd_op,
  input  logic [SEED_W-1:0]  seed_dat,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               abort,
  output logic [OUT_W-1:0]   rnd_dat,
  output logic               rnd_vld,
  input  logic               rnd_rdy,
  output logic               busy,
  output logic [SEED_W-1:0]  seed_q,
  output logic [1:0]         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holds valid and data stable until that edge.

  localparam int LAT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEED_W-1:0]  seed_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [OUT_W-1:0]   rnd_dat_q, rnd_dat_d;
  logic               rnd_vld_q, rnd_vld_d;
  logic [SEED_W-1:0]  prod_q [MUL_LAT];
  logic [SEED_W-1:0]  new_seed;
  logic [OUT_W-1:0]   new_word;

  // The pipeline samples seed_q every cycle; seed_q is stable for the whole CALC window
  // and the cycle before it, so the tail holds exactly seed_q*LCG_MULT at commit time.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
    end else begin
      prod_q[0] <= seed_q * LCG_MULT;
      for (int i = 1; i < MUL_LAT; i++) prod_q[i] <= prod_q[i-1];
    end
  end

  assign new_seed = prod_q[MUL_LAT-1] + LCG_INCR;

`ifdef PRNG_LCG_WHITEN_EN
  assign new_word = new_seed[OUT_LSB +: OUT_W] ^ new_seed[SEED_W-1 -: OUT_W];
`else
  assign new_word = new_seed[OUT_LSB +: OUT_W];
`endif

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    rem_d     = rem_q;
    lat_d     = lat_q;
    rnd_dat_d = rnd_dat_q;
    rnd_vld_d = rnd_vld_q;
    if (abort) begin
      state_d   = IDLE;
      rnd_vld_d = 1'b0;
      rem_d     = '0;
      lat_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_vld) begin
            if (!cmd_op) begin
              seed_d = seed_dat;
            end else if (burst_len != '0) begin
              rem_d   = burst_len;
              lat_d   = '0;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          if (lat_q == LAT_LAST) begin
            seed_d    = new_seed;
            rnd_dat_d = new_word;
            rnd_vld_d = 1'b1;
            rem_d     = rem_q - 1'b1;
            lat_d     = '0;
            state_d   = EMIT;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
        EMIT: begin
          if (rnd_rdy) begin
            rnd_vld_d = 1'b0;
            state_d   = (rem_q != '0) ? CALC : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      seed_q    <= '0;
      rem_q     <= '0;
      lat_q     <= '0;
      rnd_dat_q <= '0;
      rnd_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      rem_q     <= rem_d;
      lat_q     <= lat_d;
      rnd_dat_q <= rnd_dat_d;
      rnd_vld_q <= rnd_vld_d;
    end
  end

  assign cmd_rdy   = (state_q == IDLE) && !abort;
  assign busy      = (state_q != IDLE);
  assign rnd_dat   = rnd_dat_q;
  assign rnd_vld   = rnd_vld_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prng_lcg_multi.sv
// Bench for prng_lcg_multi (default build): directed cases plus a short randomised run,
// with a reference LCG feeding an expected-word queue checked at each output handshake.
module tb_prng_lcg_multi;

  logic        clk;
  logic        rst_b;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        cmd_op;
  logic [31:0] seed_dat;
  logic [7:0]  burst_len;
  logic        abort;
  logic [14:0] rnd_dat;
  logic        rnd_vld;
  logic        rnd_rdy;
  logic        busy;
  logic [31:0] seed_q;
  logic [1:0]  dbg_state;

  prng_lcg_multi dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .cmd_op    (cmd_op),
    .seed_dat  (seed_dat),
    .burst_len (burst_len),
    .abort     (abort),
    .rnd_dat   (rnd_dat),
    .rnd_vld   (rnd_vld),
    .rnd_rdy   (rnd_rdy),
    .busy      (busy),
    .seed_q    (seed_q),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          hs_cnt = 0;
  logic        rdy_rand = 1'b0;
  logic [31:0] model_seed = '0;
  logic [14:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] lcg(input logic [31:0] s);
    logic [31:0] r;
    r = s * 32'd1103515245 + 32'd12345;
    return r;
  endfunction

  function automatic logic [14:0] word_of(input logic [31:0] s);
    return s[30:16];
  endfunction

  // driver tasks
  task automatic send_cmd(input logic op, input logic [31:0] sd, input logic [7:0] len);
    int g;
    g = 0;
    cmd_op = op; seed_dat = sd; burst_len = len; cmd_vld = 1'b1;
    @(negedge clk);
    while (!cmd_rdy && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!cmd_rdy) chk("cmd_accept_timeout", 0, 1);
    if (op == 1'b0) begin
      model_seed = sd;
    end else begin
      for (int i = 0; i < len; i++) begin
        model_seed = lcg(model_seed);
        exp_q.push_back(word_of(model_seed));
      end
    end
    @(posedge clk);
    #1 cmd_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (busy || exp_q.size() != 0) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_vld();
    int g;
    g = 0;
    @(negedge clk);
    while (!rnd_vld && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("wait_vld", rnd_vld, 1);
  endtask

  // scoreboard: a word leaves on the next edge when valid and ready are both high
  always @(negedge clk) begin
    if (rst_b && rnd_vld && rnd_rdy) begin
      hs_cnt++;
      if (exp_q.size() == 0) chk("unexpected_word", rnd_dat, 0);
      else chk("rnd_dat", rnd_dat, exp_q.pop_front());
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) rnd_rdy = 1'($urandom_range(0, 1));
  end

  initial begin
    logic [31:0] s2;
    logic [14:0] held;
    int          hs0;
    logic        bad;

    rst_b = 1'b0; cmd_vld = 1'b0; cmd_op = 1'b0; seed_dat = '0; burst_len = '0;
    abort = 1'b0; rnd_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    chk("rst_rnd_vld", rnd_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_seed", seed_q, 0);
    chk("rst_rnd_dat", rnd_dat, 0);

    // seed 1, single word, latency
    @(posedge clk); #1 rnd_rdy = 1'b1;
    send_cmd(1'b0, 32'd1, 8'd0);
    send_cmd(1'b1, 32'd0, 8'd1);
    @(negedge clk);
    chk("lat_vld_early", rnd_vld, 0);
    chk("lat_busy", busy, 1);
    @(negedge clk);
    chk("lat_vld", rnd_vld, 1);
    chk("seed1_word", rnd_dat, 16838);
    chk("seed1_seed", seed_q, 32'h41C67EA6);
    wait_idle();

    // seed 0, two words
    send_cmd(1'b0, 32'd0, 8'd0);
    send_cmd(1'b1, 32'd0, 8'd2);
    wait_idle();
    chk("seed0_final", seed_q, 32'd3554416254);

    // back-pressure on word 1 of a 3-burst
    @(posedge clk); #1 rnd_rdy = 1'b0;
    hs0 = hs_cnt;
    send_cmd(1'b1, 32'd0, 8'd3);
    wait_vld();
    held = rnd_dat;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (!rnd_vld || rnd_dat !== held) bad = 1'b1;
    end
    chk("bp_stable", bad, 0);
    @(posedge clk); #1 rnd_rdy = 1'b1;
    wait_idle();
    chk("bp_words", hs_cnt - hs0, 3);
    chk("bp_busy", busy, 0);

    // abort while word 2 of a 4-burst is pending
    @(posedge clk); #1 rnd_rdy = 1'b0;
    s2 = lcg(lcg(model_seed));
    send_cmd(1'b1, 32'd0, 8'd4);
    wait_vld();
    @(posedge clk); #1 rnd_rdy = 1'b1;
    @(posedge clk); #1 rnd_rdy = 1'b0;
    wait_vld();
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_cmd_rdy", cmd_rdy, 0);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_vld", rnd_vld, 0);
    chk("abort_busy", busy, 0);
    chk("abort_seed", seed_q, s2);
    exp_q.delete();
    model_seed = s2;
    @(posedge clk); #1 rnd_rdy = 1'b1;
    send_cmd(1'b1, 32'd0, 8'd2);
    wait_idle();
    chk("abort_resume_seed", seed_q, model_seed);

    // zero-length burst is a no-op
    hs0 = hs_cnt;
    send_cmd(1'b1, 32'd0, 8'd0);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy || rnd_vld) bad = 1'b1;
    end
    chk("len0_idle", bad, 0);
    chk("len0_words", hs_cnt - hs0, 0);

    // abort together with a command: not accepted
    @(posedge clk);
    #1 abort = 1'b1; cmd_vld = 1'b1; cmd_op = 1'b0; seed_dat = 32'hDEADBEEF;
    @(negedge clk);
    chk("abort_cmd_block", cmd_rdy, 0);
    @(posedge clk);
    #1 abort = 1'b0; cmd_vld = 1'b0;
    @(negedge clk);
    chk("abort_cmd_seed", seed_q, model_seed);

    // randomised seeds, lengths and consumer stalls
    rdy_rand = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_cmd(1'b0, $urandom, 8'd0);
      send_cmd(1'b1, 32'd0, 8'($urandom_range(1, 6)));
      wait_idle();
    end
    rdy_rand = 1'b0;
    @(posedge clk); #1 rnd_rdy = 1'b1;
    @(negedge clk);
    chk("rand_seed", seed_q, model_seed);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
